// File: rtl/res_accum_if.sv
// -----------------------------------------------------------------------------
// res_accum_if
// Bundle of the result-pair input stream and the frame-result output stream
// of res_accum.
//   master : side that drives beats and takes results (producer/consumer)
//   slave  : the accumulator itself
// Signals:
//   in_valid/in_ready          input beat handshake
//   in_res1/in_res2 [32:0]     unsigned operand pair from the adder stage
//   in_last                    beat closes the frame
//   out_valid/out_ready        frame result handshake
//   out_acc [ACC_W-1:0]        frame total
//   out_cnt [CNT_W-1:0]        beats in the frame
//   out_ovf                    accumulator overflowed during the frame
// -----------------------------------------------------------------------------
interface res_accum_if #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [32:0]      in_res1;
   logic [32:0]      in_res2;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_acc;
   logic [CNT_W-1:0] out_cnt;
   logic             out_ovf;

   modport master (
      output in_valid, in_res1, in_res2, in_last, out_ready,
      input  in_ready, out_valid, out_acc, out_cnt, out_ovf
   );

   modport slave (
      input  in_valid, in_res1, in_res2, in_last, out_ready,
      output in_ready, out_valid, out_acc, out_cnt, out_ovf
   );
endinterface

// File: rtl/res_accum.sv
// -----------------------------------------------------------------------------
// res_accum
// Sums each accepted (res1, res2) pair, accumulates the sums over a frame
// closed by in_last, and presents total / beat count / sticky overflow on a
// valid/ready output held until taken.
// Parameters:
//   ACC_W  accumulator width (>= 34)
//   CNT_W  beat counter width (saturating)
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset
//   bus    res_accum_if.slave (input beat stream + frame result stream)
// Build option:
//   RES_ACCUM_SAT_EN  defined   -> accumulator saturates at 2^ACC_W-1
//                     undefined -> accumulator wraps modulo 2^ACC_W
//   In both modes out_ovf is sticky until the frame handshake.
// -----------------------------------------------------------------------------
module res_accum #(
   parameter int ACC_W = 40,
   parameter int CNT_W = 8
) (
   input logic        clk,
   input logic        rst,
   res_accum_if.slave bus
);

   localparam logic [0:0] ST_ACC  = 1'b0;
   localparam logic [0:0] ST_DONE = 1'b1;

   logic [0:0]       state_q, state_d;
   logic             r_vld_q, r_vld_d;
   logic [33:0]      r_sum_q, r_sum_d;
   logic             r_last_q, r_last_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;

   logic             in_ready;
   logic             capture;
   logic [ACC_W:0]   sum_ext;   // one extra bit catches the carry-out

   // The input register may refill in the same cycle it is consumed (ACC),
   // which gives one beat per cycle; in DONE it holds at most one beat.
   assign in_ready = !r_vld_q || (state_q == ST_ACC);
   assign capture  = bus.in_valid && in_ready;
   assign sum_ext  = {1'b0, acc_q} + {{(ACC_W-33){1'b0}}, r_sum_q};

   always_comb begin
      // NOTE: every next-state variable gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      state_d  = state_q;
      r_vld_d  = r_vld_q;
      r_sum_d  = r_sum_q;
      r_last_d = r_last_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;

      if (capture) begin
         r_vld_d  = 1'b1;
         r_sum_d  = {1'b0, bus.in_res1} + {1'b0, bus.in_res2};
         r_last_d = bus.in_last;
      end

      case (state_q)
         ST_ACC: begin
            if (r_vld_q) begin
               if (!capture) r_vld_d = 1'b0;
`ifdef RES_ACCUM_SAT_EN
               acc_d = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
               acc_d = sum_ext[ACC_W-1:0];
`endif
               ovf_d = ovf_q | sum_ext[ACC_W];
               if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
               if (r_last_q) state_d = ST_DONE;
            end
         end
         default: begin  // ST_DONE: r is left pending until the next frame
            if (bus.out_ready) begin
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = ST_ACC;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_ACC;
         r_vld_q  <= 1'b0;
         r_sum_q  <= '0;
         r_last_q <= 1'b0;
         acc_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q  <= state_d;
         r_vld_q  <= r_vld_d;
         r_sum_q  <= r_sum_d;
         r_last_q <= r_last_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.out_acc   = acc_q;
   assign bus.out_cnt   = cnt_q;
   assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_res_accum.sv
// -----------------------------------------------------------------------------
// tb_res_accum
// Directed bench for res_accum. Two instances: a default-width one (m) and a
// narrow one (s, ACC_W=34, CNT_W=2) for the overflow and count-saturation
// cases. Inputs change 1 time unit after a rising edge; outputs are sampled
// at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_res_accum;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   res_accum_if #(.ACC_W(40), .CNT_W(8)) m ();
   res_accum_if #(.ACC_W(34), .CNT_W(2)) s ();

   res_accum #(.ACC_W(40), .CNT_W(8)) u_main  (.clk(clk), .rst(rst), .bus(m));
   res_accum #(.ACC_W(34), .CNT_W(2)) u_small (.clk(clk), .rst(rst), .bus(s));

   localparam logic [32:0] MAX33 = 33'h1_FFFF_FFFF;
`ifdef RES_ACCUM_SAT_EN
   localparam logic [63:0] OVF_ACC = 64'h3_FFFF_FFFF;
`else
   localparam logic [63:0] OVF_ACC = 64'h3_FFFF_FFFC;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one beat on the selected DUT and return #1 after the edge that
   // accepted it; in_valid is dropped so back-to-back calls lose no cycle.
   task automatic send(input bit sm, input logic [32:0] a, input logic [32:0] b,
                       input logic last);
      bit rdy;
      int n;
      n = 0;
      if (sm) begin
         s.in_valid = 1'b1; s.in_res1 = a; s.in_res2 = b; s.in_last = last;
      end else begin
         m.in_valid = 1'b1; m.in_res1 = a; m.in_res2 = b; m.in_last = last;
      end
      while (n < 20) begin
         rdy = sm ? s.in_ready : m.in_ready;
         @(posedge clk); #1;
         if (rdy) break;
         n++;
      end
      if (n == 20) check("accept_timeout", 64'd1, 64'd0);
      if (sm) s.in_valid = 1'b0; else m.in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check_main(input string tag, input logic v, input logic [63:0] acc,
                             input logic [63:0] cnt, input logic ovf);
      check({tag, "_valid"}, 64'(m.out_valid), 64'(v));
      check({tag, "_acc"},   64'(m.out_acc),   acc);
      check({tag, "_cnt"},   64'(m.out_cnt),   cnt);
      check({tag, "_ovf"},   64'(m.out_ovf),   64'(ovf));
   endtask

   initial begin
      bit rdy;
      int k;
      int got;

      m.in_valid = 1'b0; m.in_res1 = '0; m.in_res2 = '0; m.in_last = 1'b0; m.out_ready = 1'b0;
      s.in_valid = 1'b0; s.in_res1 = '0; s.in_res2 = '0; s.in_last = 1'b0; s.out_ready = 1'b0;

      // Reset state
      #1;
      check_main("reset", 1'b0, 64'd0, 64'd0, 1'b0);
      check("reset_in_ready", 64'(m.in_ready), 64'd1);
      tick(); tick();
      rst = 1'b1;

      // Back-to-back frame, consumer always ready
      m.out_ready = 1'b1;
      send(0, 33'd1, 33'd2, 1'b0);
      send(0, 33'd3, 33'd4, 1'b0);
      send(0, 33'd5, 33'd6, 1'b1);
      check("b2b_valid_early", 64'(m.out_valid), 64'd0);
      tick();
      check_main("b2b", 1'b1, 64'd21, 64'd3, 1'b0);
      tick();
      check("b2b_valid_one_cycle", 64'(m.out_valid), 64'd0);

      // Backpressure while DONE
      m.out_ready = 1'b0;
      send(0, 33'd10, 33'd20, 1'b1);
      m.in_valid = 1'b1; m.in_res1 = 33'd1; m.in_res2 = 33'd1; m.in_last = 1'b0;
      tick();   // result appears, (1,1) absorbed into r
      check_main("bp_stall0", 1'b1, 64'd30, 64'd1, 1'b0);
      check("bp_in_ready0", 64'(m.in_ready), 64'd0);
      m.in_res1 = 33'd2; m.in_res2 = 33'd2; m.in_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check_main("bp_stall", 1'b1, 64'd30, 64'd1, 1'b0);
         check("bp_in_ready", 64'(m.in_ready), 64'd0);
      end
      m.out_ready = 1'b1;
      tick();   // handshake edge
      check("bp_valid_drop", 64'(m.out_valid), 64'd0);
      check("bp_in_ready_back", 64'(m.in_ready), 64'd1);
      send(0, 33'd2, 33'd2, 1'b1);
      tick();
      check_main("bp_second", 1'b1, 64'd6, 64'd2, 1'b0);
      tick();

      // Overflow on the narrow instance
      s.out_ready = 1'b1;
      send(1, MAX33, MAX33, 1'b0);
      send(1, MAX33, MAX33, 1'b1);
      tick();
      check("ovf_valid", 64'(s.out_valid), 64'd1);
      check("ovf_acc",   64'(s.out_acc),   OVF_ACC);
      check("ovf_cnt",   64'(s.out_cnt),   64'd2);
      check("ovf_flag",  64'(s.out_ovf),   64'd1);
      tick();
      check("ovf_cleared", 64'(s.out_ovf), 64'd0);

      // Beat counter saturation on the narrow instance
      for (int i = 0; i < 5; i++) send(1, 33'd0, 33'd1, (i == 4));
      tick();
      check("cnt_sat_valid", 64'(s.out_valid), 64'd1);
      check("cnt_sat_cnt",   64'(s.out_cnt),   64'd3);
      check("cnt_sat_acc",   64'(s.out_acc),   64'd5);
      check("cnt_sat_ovf",   64'(s.out_ovf),   64'd0);
      tick();

      // Reset in the middle of a frame
      send(0, 33'd7, 33'd7, 1'b0);
      send(0, 33'd8, 33'd8, 1'b0);
      rst = 1'b0;
      #1;
      check_main("rst_mid", 1'b0, 64'd0, 64'd0, 1'b0);
      check("rst_mid_in_ready", 64'(m.in_ready), 64'd1);
      tick();
      check_main("rst_hold", 1'b0, 64'd0, 64'd0, 1'b0);
      tick();
      rst = 1'b1;
      send(0, 33'd1, 33'd0, 1'b1);
      tick();
      check_main("rst_after", 1'b1, 64'd1, 64'd1, 1'b0);
      tick();

      // Single-beat frames offered every cycle
      k = 1; got = 0;
      m.in_valid = 1'b1; m.in_res1 = 33'd1; m.in_res2 = 33'd0; m.in_last = 1'b1;
      for (int c = 0; c < 30 && got < 4; c++) begin
         rdy = m.in_ready && m.in_valid;
         tick();
         if (m.out_valid) begin
            check("single_acc", 64'(m.out_acc), 64'(got + 1));
            check("single_cnt", 64'(m.out_cnt), 64'd1);
            got++;
         end
         if (rdy) begin
            k++;
            if (k > 4) m.in_valid = 1'b0;
            else       m.in_res1  = 33'(k);
         end
      end
      check("single_results", 64'(got), 64'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
